// File: rtl/row_word_patcher_pkg.sv
// Shared definitions for the row word patcher: operation codes, FSM
// state encodings and default geometry.
package row_word_patcher_pkg;

  localparam int DEF_WORDS    = 32;
  localparam int DEF_TGT_BITS = 32;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_INSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  // FSM encodings are plain constants so older tools and checkers can match them.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PATCH  = 2'd1;
  localparam logic [1:0] S_MORE   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

endpackage

// File: rtl/row_word_patcher_if.sv
// Request and commit bus between samControl (master) and the patcher (slave).
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge; ready may change freely and never depends
// on a transfer in the same cycle. Request channel: req_valid/req_ready.
// Commit channel: row_valid/row_ready.
interface row_word_patcher_if
  import row_word_patcher_pkg::*;
#(
  parameter int WORDS    = DEF_WORDS,
  parameter int TGT_BITS = DEF_TGT_BITS,
  parameter int ADR_BITS = $clog2(WORDS),
  parameter int BE_BITS  = TGT_BITS / 8,
  parameter int ROW_BITS = WORDS * TGT_BITS
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic                req_last;
  logic [ROW_BITS-1:0] row_in;
  logic [ADR_BITS-1:0] wd_adr;
  logic [TGT_BITS-1:0] target;
  logic [BE_BITS-1:0]  byte_en;
  logic [ROW_BITS-1:0] row_out;
  logic                row_valid;
  logic                row_ready;
  logic [TGT_BITS-1:0] evicted;
  logic                err;
  logic                busy;

  modport master (
    output req_valid, req_op, req_last, row_in, wd_adr, target, byte_en, row_ready,
    input  req_ready, row_out, row_valid, evicted, err, busy
  );

  modport slave (
    input  req_valid, req_op, req_last, row_in, wd_adr, target, byte_en, row_ready,
    output req_ready, row_out, row_valid, evicted, err, busy
  );
endinterface

// File: rtl/row_word_patcher_row_shift_unit.sv
// Combinational row editor: computes the row after one WRITE, INSERT or
// DELETE, the word pushed out by a shift, and whether the op was illegal.
module row_shift_unit
  import row_word_patcher_pkg::*;
#(
  parameter int WORDS    = DEF_WORDS,
  parameter int TGT_BITS = DEF_TGT_BITS,
  parameter int ADR_BITS = $clog2(WORDS),
  parameter int BE_BITS  = TGT_BITS / 8,
  parameter int ROW_BITS = WORDS * TGT_BITS,
  parameter logic [TGT_BITS-1:0] DEL_FILL = {TGT_BITS{1'b1}}
) (
  input  logic [ROW_BITS-1:0] row,
  input  logic [ADR_BITS-1:0] adr,
  input  logic [1:0]          op,
  input  logic [TGT_BITS-1:0] target,
  input  logic [BE_BITS-1:0]  byte_en,
  output logic [ROW_BITS-1:0] next_row,
  output logic [TGT_BITS-1:0] evicted,
  output logic                evict_vld,
  output logic                bad
);
  int a_i;
  assign a_i = int'(adr);

  // Apply one op; an illegal op or address leaves the row untouched.
  always_comb begin
    next_row  = row;
    evicted   = '0;
    evict_vld = 1'b0;
    bad       = 1'b0;
    if (op == OP_RSVD || a_i >= WORDS) begin
      bad = 1'b1;
    end else begin
      case (op)
        OP_WRITE: begin
          for (int b = 0; b < BE_BITS; b++) begin
            if (byte_en[b]) next_row[a_i*TGT_BITS + b*8 +: 8] = target[b*8 +: 8];
          end
        end
        OP_INSERT: begin
          for (int i = 1; i < WORDS; i++) begin
            if (i > a_i) next_row[i*TGT_BITS +: TGT_BITS] = row[(i-1)*TGT_BITS +: TGT_BITS];
          end
          next_row[a_i*TGT_BITS +: TGT_BITS] = target;
          evicted   = row[ROW_BITS-1 -: TGT_BITS];
          evict_vld = 1'b1;
        end
        OP_DELETE: begin
          for (int i = 0; i < WORDS - 1; i++) begin
            if (i >= a_i) next_row[i*TGT_BITS +: TGT_BITS] = row[(i+1)*TGT_BITS +: TGT_BITS];
          end
          next_row[ROW_BITS-1 -: TGT_BITS] = DEL_FILL;
          evicted   = row[a_i*TGT_BITS +: TGT_BITS];
          evict_vld = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
  end
endmodule

// File: rtl/row_word_patcher.sv
// Captures a row, applies a burst of word ops to it one per PATCH cycle,
// then holds the patched row until samControl takes it.
module row_word_patcher
  import row_word_patcher_pkg::*;
#(
  parameter int WORDS    = DEF_WORDS,
  parameter int TGT_BITS = DEF_TGT_BITS,
  parameter int ADR_BITS = $clog2(WORDS),
  parameter int BE_BITS  = TGT_BITS / 8,
  parameter int ROW_BITS = WORDS * TGT_BITS,
  parameter logic [TGT_BITS-1:0] DEL_FILL = {TGT_BITS{1'b1}}
) (
  input  logic              clk,
  input  logic              reset_n,
  row_word_patcher_if.slave bus,
  output logic [1:0]        state_dbg
);
  logic [1:0]          state;
  logic                alive;
  logic [ROW_BITS-1:0] row_q;
  logic [TGT_BITS-1:0] evicted_q;
  logic                err_q;
  logic [1:0]          op_q;
  logic [ADR_BITS-1:0] adr_q;
  logic [TGT_BITS-1:0] tgt_q;
  logic [BE_BITS-1:0]  be_q;
  logic                last_q;
  logic [ROW_BITS-1:0] nx_row;
  logic [TGT_BITS-1:0] nx_ev;
  logic                nx_ev_vld;
  logic                nx_bad;
  logic                req_fire;

  row_shift_unit #(
    .WORDS(WORDS), .TGT_BITS(TGT_BITS), .ADR_BITS(ADR_BITS),
    .BE_BITS(BE_BITS), .ROW_BITS(ROW_BITS), .DEL_FILL(DEL_FILL)
  ) u_shift (
    .row(row_q), .adr(adr_q), .op(op_q), .target(tgt_q), .byte_en(be_q),
    .next_row(nx_row), .evicted(nx_ev), .evict_vld(nx_ev_vld), .bad(nx_bad)
  );

  // alive keeps req_ready low until the first edge after reset releases.
  assign bus.req_ready = alive && (state == S_IDLE || state == S_MORE);
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign bus.row_out   = row_q;
  assign bus.evicted   = evicted_q;
  assign bus.err       = err_q;
  assign bus.row_valid = (state == S_COMMIT);
  assign bus.busy      = (state != S_IDLE);
  assign state_dbg     = state;

  // Burst FSM plus the working row and latched request fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      alive     <= 1'b0;
      row_q     <= '0;
      evicted_q <= '0;
      err_q     <= 1'b0;
      op_q      <= OP_WRITE;
      adr_q     <= '0;
      tgt_q     <= '0;
      be_q      <= '0;
      last_q    <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            row_q  <= bus.row_in;
            op_q   <= bus.req_op;
            adr_q  <= bus.wd_adr;
            tgt_q  <= bus.target;
            be_q   <= bus.byte_en;
            last_q <= bus.req_last;
            err_q  <= 1'b0;
            state  <= S_PATCH;
          end
        end
        S_PATCH: begin
          row_q <= nx_row;
          if (nx_ev_vld) evicted_q <= nx_ev;
          if (nx_bad) err_q <= 1'b1;
          state <= last_q ? S_COMMIT : S_MORE;
        end
        S_MORE: begin
          if (req_fire) begin
            op_q   <= bus.req_op;
            adr_q  <= bus.wd_adr;
            tgt_q  <= bus.target;
            be_q   <= bus.byte_en;
            last_q <= bus.req_last;
            state  <= S_PATCH;
          end
        end
        default: begin
          if (bus.row_ready) state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_row_word_patcher.sv
// Directed and random bursts against a queue-based row model.
module tb_row_word_patcher;
  import row_word_patcher_pkg::*;

  localparam int WORDS    = 4;
  localparam int TGT_BITS = 16;
  localparam int ROW_BITS = 64;
  localparam logic [15:0] DEL_FILL = 16'hFFFF;
  localparam logic [63:0] ROW0 = 64'h4444_3333_2222_1111;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  row_word_patcher_if #(.WORDS(WORDS), .TGT_BITS(TGT_BITS)) bus();

  row_word_patcher #(.WORDS(WORDS), .TGT_BITS(TGT_BITS), .DEL_FILL(DEL_FILL)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model: row as a queue of words, low word first
  logic [15:0] m_q[$];
  logic [15:0] m_ev = '0;
  logic        m_err = 1'b0;
  // scoreboard entries: {row, evicted, err}
  logic [80:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  function automatic logic [63:0] model_row();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < WORDS; i++) r[i*16 +: 16] = m_q[i];
    return r;
  endfunction

  task automatic model_apply(input logic [1:0] op, input int a, input logic [15:0] t,
                             input logic [1:0] be);
    logic [15:0] w;
    if (op == 2'b11 || a >= WORDS) begin
      m_err = 1'b1;
    end else if (op == 2'b00) begin
      w = m_q[a];
      for (int b = 0; b < 2; b++) if (be[b]) w[b*8 +: 8] = t[b*8 +: 8];
      m_q[a] = w;
    end else if (op == 2'b01) begin
      m_q.insert(a, t);
      m_ev = m_q.pop_back();
    end else begin
      m_ev = m_q[a];
      m_q.delete(a);
      m_q.push_back(DEL_FILL);
    end
  endtask

  // driver: call at a negedge; returns at the negedge after the handshake edge
  task automatic send_op(input logic [1:0] op, input int a, input logic [15:0] t,
                         input logic [1:0] be, input logic last, input logic [63:0] row,
                         input bit first);
    int cnt;
    if (first) begin
      m_q.delete();
      for (int i = 0; i < WORDS; i++) m_q.push_back(row[i*16 +: 16]);
      m_err = 1'b0;
    end
    model_apply(op, a, t, be);
    if (last) exp_q.push_back({model_row(), m_ev, m_err});
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_last  = last;
    bus.row_in    = row;
    bus.wd_adr    = 2'(a);
    bus.target    = t;
    bus.byte_en   = be;
    cnt = 0;
    while (!bus.req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) timeout_fail("req_handshake");
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // commit checker: waits for row_valid, compares against scoreboard, stalls, takes row
  task automatic commit_check(input string tag, input int stall);
    int cnt;
    logic [80:0] e;
    cnt = 0;
    while (!bus.row_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) timeout_fail({tag, "_row_valid"});
    if (exp_q.size() == 0) begin
      timeout_fail({tag, "_scoreboard_empty"});
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, "_row"}, bus.row_out, e[80:17]);
    chk({tag, "_evicted"}, 64'(bus.evicted), 64'(e[16:1]));
    chk({tag, "_err"}, 64'(bus.err), 64'(e[0]));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 64'(bus.row_valid), 64'd1);
      chk({tag, "_stall_row"}, bus.row_out, e[80:17]);
    end
    bus.row_ready = 1'b1;
    @(negedge clk);
    bus.row_ready = 1'b0;
    chk({tag, "_done_valid"}, 64'(bus.row_valid), 64'd0);
    chk({tag, "_done_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int nops;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_last = 1'b0; bus.row_in = '0;
    bus.wd_adr = '0; bus.target = '0; bus.byte_en = '0; bus.row_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_row_out", bus.row_out, 64'd0);
    chk("rst_evicted", 64'(bus.evicted), 64'd0);
    chk("rst_row_valid", 64'(bus.row_valid), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(S_IDLE));
    reset_n = 1'b1;
    #1;
    chk("rel_req_ready_pre_edge", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("rel_req_ready_post_edge", 64'(bus.req_ready), 64'd1);

    // single WRITE, latency and byte mask
    send_op(2'b00, 2, 16'hABCD, 2'b01, 1'b1, ROW0, 1'b1);
    chk("t1_patch_row_valid", 64'(bus.row_valid), 64'd0);
    chk("t1_patch_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    chk("t1_cycle2_row_valid", 64'(bus.row_valid), 64'd1);
    chk("t1_row_literal", bus.row_out, 64'h4444_33CD_2222_1111);
    commit_check("t1_write", 0);

    // INSERT, DELETE
    send_op(2'b01, 1, 16'h1500, 2'b00, 1'b1, ROW0, 1'b1);
    commit_check("t2_insert", 0);
    send_op(2'b10, 0, 16'h0000, 2'b00, 1'b1, ROW0, 1'b1);
    chk("t3_row_pre", 64'(bus.row_valid), 64'd0);
    @(negedge clk);
    chk("t3_row_literal", bus.row_out, 64'hFFFF_4444_3333_2222);
    commit_check("t3_delete", 0);

    // two-op burst, row_in changes in MORE are ignored
    send_op(2'b00, 0, 16'h0009, 2'b11, 1'b0, ROW0, 1'b1);
    @(negedge clk);
    chk("t4_more_row_valid", 64'(bus.row_valid), 64'd0);
    chk("t4_more_req_ready", 64'(bus.req_ready), 64'd1);
    chk("t4_more_busy", 64'(bus.busy), 64'd1);
    send_op(2'b01, 0, 16'h0005, 2'b00, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    @(negedge clk);
    chk("t4_row_literal", bus.row_out, 64'h3333_2222_0009_0005);
    commit_check("t4_burst", 0);

    // reserved op with held commit
    send_op(2'b11, 3, 16'h7777, 2'b11, 1'b1, ROW0, 1'b1);
    commit_check("t5_reserved", 5);

    // empty byte mask and top-word boundaries
    send_op(2'b00, 1, 16'h5A5A, 2'b00, 1'b1, ROW0, 1'b1);
    commit_check("t6_be_zero", 0);
    send_op(2'b01, 3, 16'h0042, 2'b11, 1'b1, ROW0, 1'b1);
    commit_check("t6_insert_top", 0);
    send_op(2'b10, 3, 16'h0000, 2'b00, 1'b1, ROW0, 1'b1);
    commit_check("t6_delete_top", 0);

    // row_ready while idle has no effect
    bus.row_ready = 1'b1;
    @(negedge clk);
    bus.row_ready = 1'b0;
    chk("t7_idle_ready_busy", 64'(bus.busy), 64'd0);

    // reset during MORE discards the burst
    send_op(2'b00, 0, 16'h1234, 2'b11, 1'b0, ROW0, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t8_rst_row_valid", 64'(bus.row_valid), 64'd0);
    chk("t8_rst_row_out", bus.row_out, 64'd0);
    chk("t8_rst_busy", 64'(bus.busy), 64'd0);
    chk("t8_rst_evicted", 64'(bus.evicted), 64'd0);
    m_ev = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_op(2'b01, 2, 16'h2525, 2'b00, 1'b1, ROW0, 1'b1);
    commit_check("t8_after_reset", 0);

    // random bursts
    for (int k = 0; k < 40; k++) begin
      r = {$urandom(), $urandom()};
      nops = $urandom_range(1, 3);
      for (int j = 0; j < nops; j++) begin
        send_op(2'($urandom_range(0, 3)), $urandom_range(0, 3), 16'($urandom()),
                2'($urandom_range(0, 3)), (j == nops - 1), (j == 0) ? r : {$urandom(), $urandom()},
                (j == 0));
        if (j != nops - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      commit_check("rand", $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
